// File: rtl/brew_sequencer_pkg.sv
// Shared types and recipe data for the brew sequencer: FSM states, drink codes,
// phase one-hot encodings and the per-drink phase duration table.
package brew_sequencer_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWaitPay,
    StServeCoffee,
    StServeMilk,
    StServeChoc,
    StServeFoam,
    StChange,
    StDone
  } state_e;

  typedef enum logic [1:0] {
    DrinkMocaccino,
    DrinkCapuccino,
    DrinkCafeConLeche,
    DrinkExpresso
  } drink_e;

  localparam logic [3:0] PhaseNone   = 4'b0000;
  localparam logic [3:0] PhaseCoffee = 4'b0001;
  localparam logic [3:0] PhaseMilk   = 4'b0010;
  localparam logic [3:0] PhaseChoc   = 4'b0100;
  localparam logic [3:0] PhaseFoam   = 4'b1000;

  // Index value meaning "no further nonzero phase in this recipe".
  localparam logic [2:0] NoPhase = 3'd4;

  // Seconds for phase idx (0 coffee, 1 milk, 2 choc, 3 foam) of drink d.
  function automatic logic [3:0] phase_dur(drink_e d, logic [1:0] idx);
    logic [15:0] row;  // {foam, choc, milk, coffee}
    case (d)
      DrinkMocaccino:    row = 16'h1223;
      DrinkCapuccino:    row = 16'h2023;
      DrinkCafeConLeche: row = 16'h0033;
      DrinkExpresso:     row = 16'h0004;
      default:           row = 16'h0000;
    endcase
    return row[{idx, 2'b00} +: 4];
  endfunction

  // First phase index >= start with a nonzero duration, or NoPhase.
  function automatic logic [2:0] first_phase_from(drink_e d, logic [2:0] start);
    logic [2:0] found;
    found = NoPhase;
    for (int i = 3; i >= 0; i--) begin
      if (3'(i) >= start && phase_dur(d, 2'(i)) != 4'd0) found = 3'(i);
    end
    return found;
  endfunction

  function automatic state_e serve_state(logic [1:0] idx);
    state_e s;
    case (idx)
      2'd0:    s = StServeCoffee;
      2'd1:    s = StServeMilk;
      2'd2:    s = StServeChoc;
      default: s = StServeFoam;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/brew_sequencer_phase_timer.sv
// Per-phase seconds counter: loads a duration, decrements on each tick and
// flags the tick that consumes the final second.
module brew_sequencer_phase_timer (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       tick_i,
  input  logic       load_i,
  input  logic [3:0] load_val_i,
  output logic [3:0] count_o,
  output logic       expire_o
);

  logic [3:0] count_q, count_d;

  // A load wins over a coincident tick, so the entry tick is never counted.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (tick_i && count_q != 4'd0) begin
      count_d = count_q - 4'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= 4'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o  = count_q;
  assign expire_o = tick_i && (count_q == 4'd1);

endmodule

// File: rtl/brew_sequencer.sv
// Drink vending sequencer: takes a selection, waits for payment (with cancel and
// idle timeout), runs the recipe's ingredient phases, returns change, holds done.
module brew_sequencer
  import brew_sequencer_pkg::*;
#(
  parameter int unsigned PAY_TIMEOUT = 15,
  parameter int unsigned DONE_HOLD   = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1s,
  input  logic       drink_valid,
  input  logic [1:0] drink,
  input  logic [2:0] cost,
  input  logic [3:0] credit,
  input  logic       cancel,
  output logic [3:0] phase,
  output logic [3:0] seconds_left,
  output logic       busy,
  output logic [3:0] change,
  output logic       change_valid,
  output logic       clear_credit,
  output logic       done
);

  state_e     state_q, state_d;
  drink_e     drink_q, drink_d;
  logic [2:0] cost_q, cost_d;
  logic [3:0] credit_prev_q;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] change_q, change_d;

  logic       serving;
  logic [2:0] cur_idx, search_start, nxt_idx;
  logic       tmr_load, tmr_expire;
  logic [3:0] tmr_val, tmr_count;

  brew_sequencer_phase_timer u_timer (
    .clk_i      (clk),
    .rst_ni     (rst),
    .tick_i     (tick_1s),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .count_o    (tmr_count),
    .expire_o   (tmr_expire)
  );

  always_comb begin
    serving = 1'b1;
    cur_idx = 3'd0;
    case (state_q)
      StServeCoffee: cur_idx = 3'd0;
      StServeMilk:   cur_idx = 3'd1;
      StServeChoc:   cur_idx = 3'd2;
      StServeFoam:   cur_idx = 3'd3;
      default:       serving = 1'b0;
    endcase
    search_start = serving ? cur_idx + 3'd1 : 3'd0;
    nxt_idx      = first_phase_from(drink_q, search_start);
  end

  always_comb begin
    state_d  = state_q;
    drink_d  = drink_q;
    cost_d   = cost_q;
    cnt_d    = cnt_q;
    change_d = change_q;
    tmr_load = 1'b0;
    tmr_val  = 4'd0;

    case (state_q)
      StIdle: begin
        if (drink_valid) begin
          drink_d = drink_e'(drink);
          cost_d  = cost;
          state_d = StWaitPay;
        end
      end
      StWaitPay: begin
        if (cancel) begin
          change_d = credit;
          state_d  = StChange;
        end else if (credit >= {1'b0, cost_q}) begin
          state_d  = (nxt_idx == NoPhase) ? StChange : serve_state(nxt_idx[1:0]);
          tmr_load = 1'b1;
          tmr_val  = (nxt_idx == NoPhase) ? 4'd0 : phase_dur(drink_q, nxt_idx[1:0]);
          if (nxt_idx == NoPhase) change_d = credit - {1'b0, cost_q};
        end else if (credit != credit_prev_q) begin
          cnt_d = 8'd0;
        end else if (tick_1s) begin
          if (32'(cnt_q) + 32'd1 >= PAY_TIMEOUT) begin
            change_d = credit;
            state_d  = StChange;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      StServeCoffee, StServeMilk, StServeChoc, StServeFoam: begin
        // Zero-length phases are skipped by jumping straight to the next nonzero one.
        if (tmr_expire) begin
          if (nxt_idx == NoPhase) begin
            change_d = credit - {1'b0, cost_q};
            state_d  = StChange;
          end else begin
            state_d  = serve_state(nxt_idx[1:0]);
            tmr_load = 1'b1;
            tmr_val  = phase_dur(drink_q, nxt_idx[1:0]);
          end
        end
      end
      StChange: state_d = StDone;
      StDone: begin
        if (tick_1s) begin
          if (32'(cnt_q) + 32'd1 >= DONE_HOLD) begin
            state_d = StIdle;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (state_d != state_q) cnt_d = 8'd0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= StIdle;
      drink_q       <= DrinkMocaccino;
      cost_q        <= 3'd0;
      credit_prev_q <= 4'd0;
      cnt_q         <= 8'd0;
      change_q      <= 4'd0;
    end else begin
      state_q       <= state_d;
      drink_q       <= drink_d;
      cost_q        <= cost_d;
      credit_prev_q <= credit;
      cnt_q         <= cnt_d;
      change_q      <= change_d;
    end
  end

  always_comb begin
    case (state_q)
      StServeCoffee: phase = PhaseCoffee;
      StServeMilk:   phase = PhaseMilk;
      StServeChoc:   phase = PhaseChoc;
      StServeFoam:   phase = PhaseFoam;
      default:       phase = PhaseNone;
    endcase
    seconds_left = serving ? tmr_count : 4'd0;
    busy         = (state_q != StIdle);
    change       = change_q;
    change_valid = (state_q == StChange);
    clear_credit = (state_q == StChange);
    done         = (state_q == StDone);
  end

endmodule

// File: tb/tb_brew_sequencer.sv
// Transaction-level bench for brew_sequencer: directed vector table, random
// transactions against a recipe/price model, and a mid-serving reset sequence.
module tb_brew_sequencer;

  localparam int PayTimeout = 15;
  localparam int DoneHold   = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick_1s = 1'b0;
  logic       drink_valid = 1'b0;
  logic [1:0] drink = 2'd0;
  logic [2:0] cost = 3'd0;
  logic [3:0] credit = 4'd0;
  logic       cancel = 1'b0;
  logic [3:0] phase, seconds_left, change;
  logic       busy, change_valid, clear_credit, done;

  int n_chk = 0;
  int n_fail = 0;

  // Recipe model: seconds of coffee, milk, chocolate, foam per drink.
  int dur_tab [4][4] = '{'{3, 2, 2, 1}, '{3, 2, 0, 2}, '{3, 3, 0, 0}, '{4, 0, 0, 0}};

  brew_sequencer #(
    .PAY_TIMEOUT (PayTimeout),
    .DONE_HOLD   (DoneHold)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .tick_1s      (tick_1s),
    .drink_valid  (drink_valid),
    .drink        (drink),
    .cost         (cost),
    .credit       (credit),
    .cancel       (cancel),
    .phase        (phase),
    .seconds_left (seconds_left),
    .busy         (busy),
    .change       (change),
    .change_valid (change_valid),
    .clear_credit (clear_credit),
    .done         (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int phase_idx(input logic [3:0] p);
    case (p)
      4'b0001: return 0;
      4'b0010: return 1;
      4'b0100: return 2;
      4'b1000: return 3;
      default: return -1;
    endcase
  endfunction

  // mode: 0 pay at cycle wt, 1 cancel at cycle wt, 2 timeout, 3 timeout with credit
  // change after the 10th waiting tick.
  task automatic run_txn(input int d, input int c, input int cr0, input int mode, input int wt,
                         input int cr_pay, input int per, input logic [15:0] exp_durs,
                         input int exp_change);
    int obs[4];
    int wait_ticks, done_ticks, pulses, got_change, chg_cyc, sl_err, oh_err, cc_err;
    int restart_pending, exp_wait;
    logic [3:0] cur_phase;
    logic cur_wait, cur_done, finished, tk;
    obs = '{0, 0, 0, 0};
    wait_ticks = 0; done_ticks = 0; pulses = 0; got_change = -1; chg_cyc = -1;
    sl_err = 0; oh_err = 0; cc_err = 0; restart_pending = 0; finished = 1'b0;
    credit = 4'(cr0); cancel = 1'b0;
    drink = 2'(d); cost = 3'(c); drink_valid = 1'b1;
    step();
    drink_valid = 1'b0;
    cur_phase = phase; cur_wait = busy && phase == 4'd0 && !change_valid && !done;
    cur_done = done;
    for (int cyc = 0; cyc < 1000; cyc++) begin
      tk = (cyc % per) == (per - 1);
      tick_1s = tk;
      if (mode == 0 && cyc >= wt) credit = 4'(cr_pay);
      if (mode == 3 && restart_pending == 1) begin
        credit = 4'(cr_pay);
        restart_pending = 2;
      end
      if (mode == 1) cancel = (cyc >= wt);
      else cancel = (cur_phase != 4'd0 || cur_done) ? 1'($urandom_range(0, 1)) : 1'b0;
      step();
      tick_1s = 1'b0;
      if (tk && cur_phase != 4'd0 && phase_idx(cur_phase) >= 0) obs[phase_idx(cur_phase)]++;
      if (tk && cur_wait) wait_ticks++;
      if (tk && cur_done) done_ticks++;
      if (mode == 3 && restart_pending == 0 && wait_ticks == 10) restart_pending = 1;
      if (phase != 4'd0 && phase_idx(phase) < 0) oh_err++;
      if (clear_credit != change_valid) cc_err++;
      if (change_valid) begin
        pulses++;
        got_change = int'(change);
        chg_cyc = cyc;
      end
      if (phase != 4'd0 && phase != cur_phase && phase_idx(phase) >= 0)
        if (int'(seconds_left) != int'(exp_durs[4*phase_idx(phase) +: 4])) sl_err++;
      if (phase == 4'd0 && seconds_left != 4'd0) sl_err++;
      if (!busy) begin
        finished = 1'b1;
        break;
      end
      cur_phase = phase; cur_done = done;
      cur_wait = busy && phase == 4'd0 && !change_valid && !done;
    end
    cancel = 1'b0;
    credit = 4'd0;
    chk("txn_finished", int'(finished), 1);
    chk("coffee_secs", obs[0], int'(exp_durs[3:0]));
    chk("milk_secs", obs[1], int'(exp_durs[7:4]));
    chk("choc_secs", obs[2], int'(exp_durs[11:8]));
    chk("foam_secs", obs[3], int'(exp_durs[15:12]));
    chk("change_value", got_change, exp_change);
    chk("change_pulses", pulses, 1);
    chk("done_ticks", done_ticks, DoneHold);
    chk("seconds_left_errs", sl_err, 0);
    chk("phase_onehot_errs", oh_err + cc_err, 0);
    if (mode == 1) chk("cancel_latency", chg_cyc, wt);
    if (mode >= 2) begin
      exp_wait = (mode == 3) ? 10 + PayTimeout : PayTimeout;
      chk("timeout_ticks", wait_ticks, exp_wait);
    end
  endtask

  typedef struct {
    int d; int c; int cr0; int mode; int wt; int cr_pay; int per;
    logic [15:0] durs; int exp_change;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int d, c, mode, cr0, cr_pay, wt, exp_change, found;
    logic [15:0] durs;
    vecs[0] = '{3, 2, 0, 0, 4, 3, 3, 16'h0004, 1};  // expresso, credit 0->3
    vecs[1] = '{1, 3, 3, 0, 0, 3, 2, 16'h2023, 0};  // capuccino, exact credit
    vecs[2] = '{0, 4, 2, 1, 2, 2, 3, 16'h0000, 2};  // mocaccino cancelled
    vecs[3] = '{2, 2, 1, 2, 0, 1, 2, 16'h0000, 1};  // cafe con leche timeout
    vecs[4] = '{2, 3, 1, 3, 0, 2, 2, 16'h0000, 2};  // timeout restarted by credit change
    vecs[5] = '{0, 5, 1, 0, 6, 9, 4, 16'h1223, 4};  // mocaccino, all four phases

    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", int'({phase, seconds_left, busy, change, change_valid,
                                clear_credit, done}), 0);
    rst = 1'b1;
    step();

    for (int i = 0; i < 6; i++)
      run_txn(vecs[i].d, vecs[i].c, vecs[i].cr0, vecs[i].mode, vecs[i].wt, vecs[i].cr_pay,
              vecs[i].per, vecs[i].durs, vecs[i].exp_change);

    for (int n = 0; n < 12; n++) begin
      d = int'($urandom_range(0, 3));
      c = int'($urandom_range(1, 7));
      mode = int'($urandom_range(0, 2));
      cr0 = int'($urandom_range(0, c - 1));
      cr_pay = (mode == 0) ? int'($urandom_range(c, 15)) : cr0;
      wt = int'($urandom_range(0, 10));
      durs = 16'h0000;
      if (mode == 0)
        for (int k = 0; k < 4; k++) durs[4*k +: 4] = 4'(dur_tab[d][k]);
      exp_change = (mode == 0) ? cr_pay - c : cr0;
      run_txn(d, c, cr0, mode, wt, cr_pay, int'($urandom_range(2, 5)), durs, exp_change);
    end

    // Reset while serving milk; cancel during serving must be ignored first.
    credit = 4'd3; drink = 2'd1; cost = 3'd3; drink_valid = 1'b1;
    step();
    drink_valid = 1'b0;
    found = 0;
    for (int cyc = 0; cyc < 200 && found == 0; cyc++) begin
      tick_1s = (cyc % 3) == 2;
      step();
      tick_1s = 1'b0;
      if (phase == 4'b0010) found = 1;
    end
    chk("reach_milk", found, 1);
    cancel = 1'b1;
    step();
    chk("cancel_ignored_phase", int'(phase), 4'b0010);
    chk("cancel_ignored_cv", int'(change_valid), 0);
    cancel = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    chk("async_reset_outputs", int'({phase, seconds_left, busy, change, change_valid,
                                      clear_credit, done}), 0);
    step();
    rst = 1'b1;
    credit = 4'd0; drink = 2'd3; cost = 3'd2; drink_valid = 1'b1;
    step();
    drink_valid = 1'b0;
    chk("accept_after_reset", int'(busy), 1);
    rst = 1'b0;
    step();
    rst = 1'b1;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
